output_serializer: RTL
======================

Name: output_serializer

Overview:
- Sits directly downstream of the multiplier/output-stage pipeline.
- Captures each quantized output vector of NUM_FEATURES x PRECISION-bit values when it is flagged valid, and buffers it in a small vector FIFO.
- Serializes each vector, feature 0 first, onto a valid/ready byte stream with a last marker per vector.
- Drives a stall request back to the pipeline's ce control so buffered results are not lost under backpressure.

Parameters:
- PRECISION, 8: bit width of each output element.
- NUM_FEATURES, 2: elements per input vector (parallel features).
- FIFO_DEPTH, 4: vector slots in the buffer; power of two, >= 2.
- STALL_MARGIN, 2: `stall` asserts when free slots <= STALL_MARGIN; range 1..FIFO_DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset; 0 = reset.
- in_valid  in  1  in_data holds a valid result vector this cycle.
- in_data  in  [PRECISION-1:0] x [NUM_FEATURES-1:0]  result vector, index 0 = feature 0.
- stall  out  1  request to deassert the pipeline ce.
- m_valid  out  1  m_data is valid.
- m_data  out  PRECISION  current serialized element.
- m_last  out  1  m_data is element NUM_FEATURES-1 of its vector.
- m_ready  in  1  downstream accepts the element when m_valid && m_ready.
- fill  out  $clog2(FIFO_DEPTH+1)  number of occupied vector slots.
- overflow  out  1  sticky: a valid vector was dropped.

Behaviour:
- Reset (rst=0 at a clock edge):
  - wr_ptr, rd_ptr, fill and element index idx clear to 0.
  - overflow clears to 0.
  - Outputs are then m_valid=0, m_last=0, stall=0, m_data=0.
  - FIFO storage is not cleared.
  - Reset mid-serialization discards all buffered vectors, including a partially sent one. No m_last is emitted for it.
- Write:
  - On in_valid=1 with pre-edge fill < FIFO_DEPTH, store in_data at wr_ptr and increment wr_ptr (wraps modulo FIFO_DEPTH).
  - On in_valid=1 with pre-edge fill == FIFO_DEPTH, drop the vector and set overflow=1. This applies even if a pop happens in the same cycle.
- Read FSM, two states:
  - IDLE: fill==0, m_valid=0.
  - SEND: fill>0, m_valid=1, m_data = fifo[rd_ptr][idx], m_last = (idx==NUM_FEATURES-1).
- Handshake in SEND:
  - On m_valid && m_ready with idx < NUM_FEATURES-1: idx increments.
  - On m_valid && m_ready with idx == NUM_FEATURES-1: idx returns to 0, rd_ptr increments (wrap), and the vector is popped.
  - After a pop, return to IDLE if no vector remains.
- Stability:
  - While m_valid=1 and m_ready=0, m_data and m_last hold unchanged.
  - m_valid never drops without a handshake, except on reset.
- Latency: a vector written at edge t produces m_valid=1 with element 0 in the cycle after edge t, i.e. 1 cycle from in_valid to first m_valid.
- Throughput: one element per cycle with m_ready=1; back-to-back vectors have no bubble.
- Fill update:
  - Simultaneous accepted write and pop: fill unchanged.
  - Write only: +1.
  - Pop only: -1.
- Stall:
  - stall is registered: stall = (FIFO_DEPTH - fill) <= STALL_MARGIN, evaluated on the post-update fill.
  - STALL_MARGIN absorbs in-flight pipeline results (ce deassert to in_valid stop).
- Overflow clears only on reset.
- Degenerate case NUM_FEATURES=1: every element has m_last=1 and every handshake pops.

Test Plan:
- Single vector {0x11,0x22} (feature0=0x11), m_ready=1 -> m_valid high for 2 cycles starting 1 cycle after in_valid; m_data 0x11 (m_last=0) then 0x22 (m_last=1); fill returns 0.
- m_ready=0, push 3 vectors on consecutive cycles (FIFO_DEPTH=4, STALL_MARGIN=2) -> fill 1,2,3; stall rises after the 2nd write; m_data holds 0x11 throughout.
- m_ready=0, push 5 vectors -> 5th dropped, overflow=1, fill=4; then m_ready=1 -> exactly 8 elements emitted in order, 4 m_last pulses.
- Full FIFO, in_valid and a final-element handshake in the same cycle -> incoming vector dropped, overflow=1, fill=3.
- Continuous in_valid every 2 cycles with m_ready=1 -> gap-free stream, wr_ptr/rd_ptr wrap past 3 correctly, data matches the scoreboard for 20 vectors.
- Assert rst=0 after element 0 of a vector has been accepted -> next cycle m_valid=0, fill=0, overflow=0; a new vector afterwards is emitted starting from its element 0.

Source files
------------

// File: rtl/output_serializer.sv
// Buffers quantized result vectors in a small vector FIFO and serializes them,
// feature 0 first, onto a valid/ready element stream with a per-vector last marker.
module output_serializer #(
  parameter int unsigned PRECISION    = 8,
  parameter int unsigned NUM_FEATURES = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STALL_MARGIN = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [NUM_FEATURES*PRECISION-1:0]   in_data,
  output logic                                stall,
  output logic                                m_valid,
  output logic [PRECISION-1:0]                m_data,
  output logic                                m_last,
  input  logic                                m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fill,
  output logic                                overflow
);

  localparam int unsigned VEC_W    = NUM_FEATURES * PRECISION;
  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FILL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int unsigned LAST_IDX = NUM_FEATURES - 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PRECISION-1:0]  m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic                  stall_q, stall_d;
  logic                  overflow_q, overflow_d;

  logic [VEC_W-1:0]      mem_q [FIFO_DEPTH];
  logic [VEC_W-1:0]      head_vec;
  logic                  wr_en;
  logic                  hs;
  logic                  pop;

  // Next-state, FIFO bookkeeping and registered output precompute
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    m_data_d   = '0;
    m_last_d   = 1'b0;
    head_vec   = '0;

    wr_en = in_valid && (fill_q != FILL_W'(FIFO_DEPTH));
    hs    = (state_q == SEND) && m_ready;
    pop   = hs && (idx_q == IDX_W'(LAST_IDX));

    if (hs) begin
      idx_d = pop ? '0 : idx_q + IDX_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (in_valid && !wr_en) begin
      overflow_d = 1'b1;
    end

    case ({wr_en, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase

    case (state_q)
      IDLE: if (wr_en) state_d = SEND;
      SEND: if (pop && !wr_en && (fill_q == FILL_W'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A vector written into an empty FIFO is forwarded so element 0 appears next cycle
    head_vec = mem_q[rd_ptr_d];
    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      head_vec = in_data;
    end

    if (state_d == SEND) begin
      for (int i = 0; i < int'(NUM_FEATURES); i++) begin
        if (IDX_W'(i) == idx_d) begin
          m_data_d = head_vec[i*PRECISION +: PRECISION];
        end
      end
      m_last_d = (idx_d == IDX_W'(LAST_IDX));
    end

    stall_d = (FILL_W'(FIFO_DEPTH) - fill_d) <= FILL_W'(STALL_MARGIN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      idx_q      <= '0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      idx_q      <= idx_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  // Vector storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign m_valid  = (state_q == SEND);
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign stall    = stall_q;
  assign fill     = fill_q;
  assign overflow = overflow_q;

endmodule
